// File: rtl/vending_machine.sv
// Soda vending machine: 20c price, credit held in 5c units, one sale per edge
// with every unit above the price returned as change on the following cycle.
module vending_machine (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_nickle,
    input  logic       i_dime,
    input  logic       i_quarter,
    output logic       o_soda,
    output logic [2:0] o_change
);

    localparam int unsigned SUM_W    = 4;
    localparam int unsigned CREDIT_W = 2;
    localparam int unsigned CHANGE_W = 3;

    localparam logic [CREDIT_W-1:0] S0  = 2'd0;
    localparam logic [CREDIT_W-1:0] S5  = 2'd1;
    localparam logic [CREDIT_W-1:0] S10 = 2'd2;
    localparam logic [CREDIT_W-1:0] S15 = 2'd3;

    localparam logic [SUM_W-1:0] PRICE       = 4'd4;
    localparam logic [SUM_W-1:0] QUARTER_VAL = 4'd5;

    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                soda_q,   soda_d;
    logic [CHANGE_W-1:0] change_q, change_d;

    logic [SUM_W-1:0] deposit_c;
    logic [SUM_W-1:0] total_c;

    // State register; reset discards any credit without returning change.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            credit_q <= S0;
            soda_q   <= 1'b0;
            change_q <= '0;
        end else begin
            credit_q <= credit_d;
            soda_q   <= soda_d;
            change_q <= change_d;
        end
    end

    // Simultaneous coins are summed; total peaks at 3 + 1 + 2 + 5 = 11 units.
    always_comb begin
        deposit_c = SUM_W'(i_nickle)
                  + {SUM_W'(i_dime) << 1}
                  + (i_quarter ? QUARTER_VAL : '0);
        total_c   = SUM_W'(credit_q) + deposit_c;

        credit_d  = credit_q;
        soda_d    = 1'b0;
        change_d  = '0;

        case (total_c)
            4'd0:    credit_d = S0;
            4'd1:    credit_d = S5;
            4'd2:    credit_d = S10;
            4'd3:    credit_d = S15;
            default: begin
                credit_d = S0;
                soda_d   = 1'b1;
                change_d = CHANGE_W'(total_c - PRICE);
            end
        endcase
    end

    assign o_soda   = soda_q;
    assign o_change = change_q;

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: directed vector table, hand-written
// asynchronous-reset sequences and randomized coins against a credit model.
module tb_vending_machine;

    logic       i_clk;
    logic       i_rst;
    logic       i_nickle;
    logic       i_dime;
    logic       i_quarter;
    logic       o_soda;
    logic [2:0] o_change;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic rst;
        logic nick;
        logic dime;
        logic quart;
        int   soda;
        int   change;
        string name;
    } vec_t;

    vec_t vecs[$];

    vending_machine dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_nickle  (i_nickle),
        .i_dime    (i_dime),
        .i_quarter (i_quarter),
        .o_soda    (o_soda),
        .o_change  (o_change)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int soda, input int change);
        check({name, ".soda"}, int'(o_soda), soda);
        check({name, ".change"}, int'(o_change), change);
    endtask

    // Drive one edge's worth of inputs, then sample just after the edge.
    task automatic step(input logic r, input logic n, input logic d, input logic q);
        i_rst     = r;
        i_nickle  = n;
        i_dime    = d;
        i_quarter = q;
        @(posedge i_clk);
        #1;
    endtask

    task automatic add(input logic r, input logic n, input logic d, input logic q,
                       input int soda, input int change, input string name);
        vec_t v;
        v.rst = r; v.nick = n; v.dime = d; v.quart = q;
        v.soda = soda; v.change = change; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        int credit;
        int total;
        logic r, n, d, q;
        int exp_soda, exp_change;

        i_rst = 1'b1; i_nickle = 1'b0; i_dime = 1'b0; i_quarter = 1'b0;
        #2;
        check_out("reset_state", 0, 0);

        // Reset row holds a quarter high to show coins are ignored in reset.
        add(1, 0, 0, 1, 0, 0, "rst_ignores_coin");
        add(0, 0, 1, 0, 0, 0, "r29_dime");
        add(0, 0, 0, 1, 1, 3, "r29_quarter");
        add(0, 0, 0, 0, 0, 0, "r29_idle");
        add(0, 1, 0, 0, 0, 0, "r30_nickel");
        add(0, 0, 1, 0, 0, 0, "r30_dime");
        add(0, 0, 0, 1, 1, 4, "r30_quarter");
        add(0, 1, 0, 0, 0, 0, "r31_n1");
        add(0, 1, 0, 0, 0, 0, "r31_n2");
        add(0, 1, 0, 0, 0, 0, "r31_n3");
        add(0, 1, 0, 0, 1, 0, "r31_n4");
        add(0, 0, 1, 0, 0, 0, "r32_dime1");
        add(0, 0, 1, 0, 1, 0, "r32_dime2");
        add(0, 0, 0, 0, 0, 0, "r32_idle");
        add(0, 1, 1, 0, 0, 0, "r33_build15");
        add(0, 1, 1, 1, 1, 7, "r33_all_coins");
        add(0, 0, 0, 1, 1, 1, "quarter_from_0");
        add(0, 1, 0, 0, 0, 0, "hold_nickel");
        add(0, 0, 0, 0, 0, 0, "hold_idle1");
        add(0, 0, 0, 0, 0, 0, "hold_idle2");
        add(0, 0, 1, 0, 0, 0, "hold_dime_to15");
        add(0, 1, 0, 0, 1, 0, "hold_nickel_sale");
        add(0, 0, 1, 1, 1, 3, "dime_quarter_0");
        add(1, 1, 1, 1, 0, 0, "rst_row2");
        add(0, 0, 1, 0, 0, 0, "post_rst_dime");
        add(0, 0, 1, 0, 1, 0, "post_rst_sale");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].nick, vecs[i].dime, vecs[i].quart);
            check_out(vecs[i].name, vecs[i].soda, vecs[i].change);
        end

        // Async reset mid-cycle drops a pending dispense pulse immediately.
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check_out("pre_async_sale", 1, 2'd0);
        #2 i_rst = 1'b1;
        #1 check_out("async_rst_outputs", 0, 0);
        #1 i_rst = 1'b0;

        // Credit S10 then a reset pulse between edges: credit lost.
        step(0, 0, 1, 0);
        check_out("r34_build10", 0, 0);
        i_dime = 1'b0;
        #2 i_rst = 1'b1;
        #1 check_out("r34_async", 0, 0);
        #1 i_rst = 1'b0;
        step(0, 0, 1, 0);
        check_out("r34_dime_no_sale", 0, 0);
        step(0, 0, 1, 0);
        check_out("r34_dime_sale", 1, 0);

        // Randomized coins against a credit model in 5c units.
        step(1, 0, 0, 0);
        credit = 0;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 39) == 0);
            n = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 2) == 0);
            q = ($urandom_range(0, 3) == 0);
            step(r, n, d, q);
            exp_soda = 0;
            exp_change = 0;
            if (r) begin
                credit = 0;
            end else begin
                total = credit + (n ? 1 : 0) + (d ? 2 : 0) + (q ? 5 : 0);
                if (total >= 4) begin
                    exp_soda = 1;
                    exp_change = total - 4;
                    credit = 0;
                end else begin
                    credit = total;
                end
            end
            check_out("random", exp_soda, exp_change);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vending_machine.md
VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL update on the rising edge of i_clk.
REQ-002 Port i_clk, input, 1 bit: system clock.
REQ-003 Port i_rst, input, 1 bit: asynchronous active-high reset.
REQ-004 Port i_nickle, input, 1 bit: a 5-cent coin is present this cycle.
REQ-005 Port i_dime, input, 1 bit: a 10-cent coin is present this cycle.
REQ-006 Port i_quarter, input, 1 bit: a 25-cent coin is present this cycle.
REQ-007 Port o_soda, output, 1 bit: dispense pulse, high for exactly one cycle per sale.
REQ-008 Port o_change, output, 3 bits: change returned, as an unsigned count of 5-cent units.
REQ-009 Encoding of o_change: 0 = 0c, 1 = 5c, 2 = 10c, 3 = 15c, 4 = 20c, up to 7 = 35c.

Function
REQ-010 Soda price SHALL be fixed at 20 cents.
REQ-011 Stored credit SHALL be one of four states: S0 (0c), S5 (5c), S10 (10c), S15 (15c), held in 5-cent units.
REQ-012 Each rising clock edge SHALL sample the three coin inputs.
REQ-013 Each coin input that is high at an edge SHALL count as one insertion of that coin.
REQ-014 A coin held high for N edges SHALL count as N coins; no edge detection is applied.
REQ-015 Deposit at an edge SHALL be 1·i_nickle + 2·i_dime + 5·i_quarter, in 5-cent units.
REQ-016 Simultaneous coins SHALL be summed; no coin is dropped and no coin has priority.
REQ-017 Let total = credit + deposit, with range 0..11 units.
REQ-018 If total < 4, credit SHALL become total, and o_soda = 0, o_change = 0 on the next cycle.
REQ-019 If total >= 4, then on the next cycle:
  - credit SHALL become 0;
  - o_soda SHALL be 1;
  - o_change SHALL be total − 4 (range 0..7).
REQ-020 At most one soda SHALL be dispensed per edge, even when total − 4 >= 4; all of the excess is returned as change.
REQ-021 o_soda and o_change SHALL be registered outputs, valid for exactly the one cycle after the sampling edge, and 0 otherwise.
REQ-022 An edge with no coin input high SHALL leave credit unchanged and drive o_soda = 0, o_change = 0.
REQ-023 Internal arithmetic SHALL be at least 4 bits wide so that total never wraps; o_change SHALL never exceed 7.
REQ-024 Coin inputs are synchronous to i_clk; no synchronizer is required.

Reset
REQ-025 While i_rst = 1, the block SHALL asynchronously force: credit = S0, o_soda = 0, o_change = 3'b000.
REQ-026 While i_rst = 1, coin inputs SHALL be ignored.
REQ-027 On i_rst assertion mid-operation, any accumulated credit SHALL be discarded, with no change returned.
REQ-028 Coins sampled at the first rising edge after i_rst deasserts SHALL be counted normally.

Verification
REQ-029 Reset, then dime for 1 cycle, then quarter for 1 cycle -> after the quarter edge: o_soda = 1, o_change = 3'b011 (15c) for one cycle; credit S0.
REQ-030 Nickel, dime, quarter on successive cycles -> credit S5, then S15; at the quarter edge: o_soda = 1, o_change = 3'b100 (20c).
REQ-031 Four nickels on four consecutive cycles (nickel held 4 cycles) -> o_soda = 1, o_change = 0 after the 4th edge only; no earlier outputs.
REQ-032 Two dimes on consecutive cycles -> exact payment: o_soda = 1, o_change = 3'b000; the following idle cycle has o_soda = 0.
REQ-033 Credit S15, then nickel + dime + quarter in the same cycle -> total 11 units: o_soda = 1, o_change = 3'b111 (35c).
REQ-034 Credit S10, then i_rst pulse between edges -> credit S0 immediately, outputs 0; a following dime gives credit S10, not a sale.
